fir_coeff_loader: RTL and testbench
===================================

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 SHALL have parameter NCOEF, default 129, meaning the number of coefficients per load (addresses 0..NCOEF-1).
REQ-002 SHALL have parameter C, default 16, meaning the coefficient width in bits.
REQ-003 SHALL have parameter AW, default 8, meaning the address width; NCOEF SHALL be no greater than 2^AW.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port nrst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-007 SHALL have port abort  input  1  terminates a load in progress.
REQ-008 SHALL have port s_valid  input  1  host coefficient valid.
REQ-009 SHALL have port s_data  input  C  host coefficient, two's complement.
REQ-010 SHALL have port s_ready  output  1  loader accepts a coefficient.
REQ-011 SHALL have port c_WE  output  1  FIR coefficient write enable; the FIR holds processing while it is high.
REQ-012 SHALL have port c_in  output  C  coefficient data to the FIR.
REQ-013 SHALL have port c_addr  output  AW  coefficient address to the FIR.
REQ-014 SHALL have port busy  output  1  high in LOAD or FLUSH.
REQ-015 SHALL have port done  output  1  high after a complete load until the next start, abort or reset.

Function
REQ-016 SHALL implement the states IDLE, LOAD, FLUSH and DONE, with all outputs registered.
REQ-017 SHALL move from IDLE or DONE to LOAD on the edge sampling start=1 and abort=0, setting c_WE=1, clearing done, and setting the accept index to 0.
REQ-018 SHALL ignore start while in LOAD or FLUSH.
REQ-019 SHALL drive s_ready=1 only in LOAD, so that a transfer occurs on each edge with s_valid=1 and s_ready=1.
REQ-020 SHALL, on each transfer, update c_in to s_data and c_addr to the index on that same edge (latency 1 edge), then increment the index.
REQ-021 SHALL hold c_in and c_addr between transfers, so that repeated FIR writes of the same pair are idempotent.
REQ-022 SHALL tolerate gaps in s_valid of any length, with no timeout.
REQ-023 SHALL, on the transfer with index NCOEF-1, go to FLUSH with s_ready=0 and c_WE still 1, so that the last coefficient is written for at least one further cycle.
REQ-024 SHALL go from FLUSH to DONE on the next edge, with c_WE=0 and done=1 on that edge.
REQ-025 SHALL, on abort=1 in LOAD or FLUSH, go to IDLE on the next edge with c_WE=0, done=0 and the index cleared; abort SHALL have priority over start and over a coincident transfer.
REQ-026 SHALL treat abort in IDLE or DONE as clearing done and going to IDLE.
REQ-027 SHALL NOT wrap the index past NCOEF-1 during a load.

Reset
REQ-028 SHALL, while nrst=0, asynchronously force state IDLE, c_WE=0, c_in=0, c_addr=0, s_ready=0, busy=0, done=0 and index 0.
REQ-029 SHALL discard a load in progress when reset is asserted, leaving no residual state, and SHALL require a new start after reset is released.

Configuration
REQ-030 SHALL, when macro FIR_COEFF_CHECKSUM_EN is defined, add input exp_sum [15:0] and output sum_ok (1 bit).
REQ-031 SHALL, with FIR_COEFF_CHECKSUM_EN defined, accumulate the sum modulo 2^16 of all accepted s_data, sign-extended or truncated to 16 bits, clearing it on start.
REQ-032 SHALL, with FIR_COEFF_CHECKSUM_EN defined, drive sum_ok to (sum == exp_sum) on the edge where done rises, hold it while in DONE, and drive it to 0 otherwise, including at reset.
REQ-033 SHALL, without FIR_COEFF_CHECKSUM_EN, omit both ports and all checksum logic, with every other behaviour unchanged.

Verification
REQ-034 SHALL verify a back-to-back load: start at edge 0, then 129 coefficients with s_valid=1 constantly and s_data=addr+1 -> c_WE high after edges 0..129, last write of addr 128 with data 129, and c_WE=0 with done=1 after edge 130.
REQ-035 SHALL verify a gappy load: s_valid toggling 1,0,1,0 -> exactly 129 transfers, c_addr strictly incrementing 0..128, and c_in held during gaps.
REQ-036 SHALL verify abort during load: abort asserted together with transfer 50 -> transfer 50 not taken, IDLE with c_WE=0 and done=0 next edge, and a following start reloading from addr 0.
REQ-037 SHALL verify reset mid-load: nrst low after 70 transfers -> all outputs 0 immediately, and no activity until a new start.
REQ-038 SHALL verify start and restart rules: start asserted in LOAD is ignored; start asserted in DONE clears done and loads again from addr 0.
REQ-039 SHALL verify the checksum feature with FIR_COEFF_CHECKSUM_EN defined: coefficients all 0x0100 with exp_sum=0x8100 -> sum_ok=1 with done; exp_sum=0x8101 -> sum_ok=0.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: streams NCOEF host coefficients into a FIR coefficient RAM.
// IDLE -> LOAD (one coefficient accepted per s_valid & s_ready edge) -> FLUSH
// (extra write cycle for the last coefficient) -> DONE. Abort returns to IDLE.
// Optional feature macro: FIR_COEFF_CHECKSUM_EN adds exp_sum/sum_ok, a
// mod-2^16 sum of the accepted coefficients compared when done rises.
module fir_coeff_loader #(
    parameter int NCOEF = 129,
    parameter int C     = 16,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic          abort,
    input  logic          s_valid,
    input  logic [C-1:0]  s_data,
    output logic          s_ready,
    output logic          c_WE,
    output logic [C-1:0]  c_in,
    output logic [AW-1:0] c_addr,
    output logic          busy,
    output logic          done
`ifdef FIR_COEFF_CHECKSUM_EN
    ,
    input  logic [15:0]   exp_sum,
    output logic          sum_ok
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_e;

    localparam logic [AW-1:0] LAST_IDX = AW'(NCOEF - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [C-1:0]  cin_q, cin_d;
    logic [AW-1:0] caddr_q, caddr_d;
    logic          cwe_q, cwe_d;
    logic          srdy_q, srdy_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // A transfer is a handshake that abort does not cancel.
    logic xfer;
    assign xfer = s_valid && srdy_q && !abort;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; abort outranks start and any coincident transfer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (abort)      state_d = S_IDLE;
                else if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (abort)                      state_d = S_IDLE;
                else if (xfer && idx_q == LAST_IDX) state_d = S_FLUSH;
            end
            S_FLUSH: state_d = abort ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next-state: flags follow the next state so they are registered
    // in step with it; coefficient pair only moves on a transfer.
    always_comb begin
        srdy_d  = (state_d == S_LOAD);
        cwe_d   = (state_d == S_LOAD) || (state_d == S_FLUSH);
        busy_d  = cwe_d;
        done_d  = (state_d == S_DONE);
        cin_d   = cin_q;
        caddr_d = caddr_q;
        idx_d   = '0;
        if (state_q == S_LOAD && state_d == S_LOAD)
            idx_d = xfer ? idx_q + AW'(1) : idx_q;
        if (xfer) begin
            cin_d   = s_data;
            caddr_d = idx_q;
        end
    end

    // Output and index registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx_q   <= '0;
            cin_q   <= '0;
            caddr_q <= '0;
            cwe_q   <= 1'b0;
            srdy_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            cin_q   <= cin_d;
            caddr_q <= caddr_d;
            cwe_q   <= cwe_d;
            srdy_q  <= srdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s_ready = srdy_q;
    assign c_WE    = cwe_q;
    assign c_in    = cin_q;
    assign c_addr  = caddr_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef FIR_COEFF_CHECKSUM_EN
    logic [15:0] s_ext;
    logic [15:0] sum_q, sum_d;
    logic        sumok_q, sumok_d;

    // Bring the coefficient to 16 bits: truncate wide, sign-extend narrow.
    if (C >= 16) begin : g_trunc
        assign s_ext = s_data[15:0];
    end else begin : g_sext
        assign s_ext = {{(16-C){s_data[C-1]}}, s_data};
    end

    // Running sum restarts with each load; sum_ok is judged as done rises.
    always_comb begin
        sum_d = sum_q;
        if (state_q != S_LOAD && state_q != S_FLUSH && state_d == S_LOAD)
            sum_d = '0;
        else if (xfer)
            sum_d = sum_q + s_ext;
        sumok_d = 1'b0;
        if (state_d == S_DONE)
            sumok_d = (state_q == S_FLUSH) ? (sum_q == exp_sum) : sumok_q;
    end

    // Checksum registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sum_q   <= '0;
            sumok_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            sumok_q <= sumok_d;
        end
    end

    assign sum_ok = sumok_q;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader (default parameters: 129 x 16-bit).
module tb_fir_coeff_loader;
    localparam int NCOEF = 129;

    logic        clk = 1'b0;
    logic        nrst, start, abort, s_valid;
    logic [15:0] s_data;
    logic        s_ready, c_WE, busy, done;
    logic [15:0] c_in;
    logic [7:0]  c_addr;
`ifdef FIR_COEFF_CHECKSUM_EN
    logic [15:0] exp_sum;
    logic        sum_ok;
`endif

    int checks = 0;
    int errors = 0;

    fir_coeff_loader #(.NCOEF(NCOEF), .C(16), .AW(8)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .c_WE(c_WE), .c_in(c_in), .c_addr(c_addr), .busy(busy), .done(done)
`ifdef FIR_COEFF_CHECKSUM_EN
        , .exp_sum(exp_sum), .sum_ok(sum_ok)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        start, abort, vld;
        logic [15:0] dat;
        logic        e_we, e_rdy, e_busy, e_done;
        logic        chkd;
        logic [7:0]  e_addr;
        logic [15:0] e_in;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_ctl(input string nm, input logic we, input logic rdy,
                           input logic bsy, input logic dn);
        chk({nm, ".c_WE"},    {31'd0, c_WE},    {31'd0, we});
        chk({nm, ".s_ready"}, {31'd0, s_ready}, {31'd0, rdy});
        chk({nm, ".busy"},    {31'd0, busy},    {31'd0, bsy});
        chk({nm, ".done"},    {31'd0, done},    {31'd0, dn});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input string nm);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_ctl({nm, ".start"}, 1, 1, 1, 0);
    endtask

    // Performs n transfers beginning at addr 0, checking address/data every edge.
    task automatic feed(input string nm, input int n, input bit gappy,
                        input bit cdat, input logic [15:0] dv);
        int idx = 0;
        int cyc = 0;
        bit ph = 1'b1;
        int exp_a = 0;
        logic [15:0] exp_d = '0;
        while (idx < n && cyc < 4 * n + 8) begin
            s_valid = gappy ? ph : 1'b1;
            s_data  = cdat ? dv : 16'(idx + 1);
            step();
            cyc++;
            if (s_valid) begin
                exp_a = idx;
                exp_d = s_data;
                idx++;
            end
            chk({nm, ".c_addr"},  {24'd0, c_addr}, 32'(exp_a));
            chk({nm, ".c_in"},    {16'd0, c_in},   {16'd0, exp_d});
            chk({nm, ".c_WE"},    {31'd0, c_WE},   32'd1);
            chk({nm, ".s_ready"}, {31'd0, s_ready}, (idx < NCOEF) ? 32'd1 : 32'd0);
            ph = !ph;
        end
        s_valid = 1'b0;
        if (idx < n) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: got %0d transfers want %0d", nm, idx, n);
        end
    endtask

    // After the last transfer: FLUSH for one edge, then DONE.
    task automatic finish_load(input string nm);
        chk_ctl({nm, ".flush"}, 1, 0, 1, 0);
        step();
        chk_ctl({nm, ".done"}, 0, 0, 0, 1);
        chk({nm, ".done_addr"}, {24'd0, c_addr}, 32'd128);
    endtask

    vec_t vt[12];

    initial begin
        vt[0]  = '{"idle",          0,0,0,16'h0000, 0,0,0,0, 1, 8'd0, 16'h0000};
        vt[1]  = '{"abort_idle",    0,1,0,16'h0000, 0,0,0,0, 1, 8'd0, 16'h0000};
        vt[2]  = '{"start_abort",   1,1,0,16'h0000, 0,0,0,0, 1, 8'd0, 16'h0000};
        vt[3]  = '{"start",         1,0,0,16'h0000, 1,1,1,0, 1, 8'd0, 16'h0000};
        vt[4]  = '{"xfer0",         0,0,1,16'h0011, 1,1,1,0, 1, 8'd0, 16'h0011};
        vt[5]  = '{"gap",           0,0,0,16'h0099, 1,1,1,0, 1, 8'd0, 16'h0011};
        vt[6]  = '{"start_in_load", 1,0,1,16'h0022, 1,1,1,0, 1, 8'd1, 16'h0022};
        vt[7]  = '{"abort_xfer",    0,1,1,16'h0033, 0,0,0,0, 0, 8'd0, 16'h0000};
        vt[8]  = '{"valid_in_idle", 0,0,1,16'h0044, 0,0,0,0, 0, 8'd0, 16'h0000};
        vt[9]  = '{"restart",       1,0,0,16'h0000, 1,1,1,0, 0, 8'd0, 16'h0000};
        vt[10] = '{"reload_addr0",  0,0,1,16'h0055, 1,1,1,0, 1, 8'd0, 16'h0055};
        vt[11] = '{"abort_load",    0,1,0,16'h0000, 0,0,0,0, 0, 8'd0, 16'h0000};

        nrst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
`ifdef FIR_COEFF_CHECKSUM_EN
        exp_sum = 16'h8100;
`endif
        #3;
        chk_ctl("reset", 0, 0, 0, 0);
        chk("reset.c_addr", {24'd0, c_addr}, 32'd0);
        chk("reset.c_in",   {16'd0, c_in},   32'd0);
        #17 nrst = 1'b1;

        // Table-driven single-cycle behaviour.
        for (int i = 0; i < 12; i++) begin
            start = vt[i].start; abort = vt[i].abort;
            s_valid = vt[i].vld; s_data = vt[i].dat;
            step();
            chk_ctl(vt[i].name, vt[i].e_we, vt[i].e_rdy, vt[i].e_busy, vt[i].e_done);
            if (vt[i].chkd) begin
                chk({vt[i].name, ".c_addr"}, {24'd0, c_addr}, {24'd0, vt[i].e_addr});
                chk({vt[i].name, ".c_in"},   {16'd0, c_in},   {16'd0, vt[i].e_in});
            end
        end
        start = 1'b0; abort = 1'b0; s_valid = 1'b0;

        // Back-to-back full load, data = addr + 1.
        do_start("b2b");
        feed("b2b", NCOEF, 1'b0, 1'b0, 16'h0);
        finish_load("b2b");
        chk("b2b.last_in", {16'd0, c_in}, 32'd129);

        // Start while DONE clears done and reloads from 0.
        do_start("redone");
        feed("redone", 1, 1'b0, 1'b0, 16'h0);
        abort = 1'b1; step(); abort = 1'b0;
        chk_ctl("redone.abort", 0, 0, 0, 0);

        // Gappy full load.
        do_start("gappy");
        feed("gappy", NCOEF, 1'b1, 1'b0, 16'h0);
        finish_load("gappy");

        // Abort coincident with transfer 50.
        do_start("ab50");
        feed("ab50", 50, 1'b0, 1'b0, 16'h0);
        abort = 1'b1; s_valid = 1'b1; s_data = 16'hBEEF;
        step();
        abort = 1'b0; s_valid = 1'b0;
        chk_ctl("ab50.abort", 0, 0, 0, 0);
        chk("ab50.addr_not_taken", {24'd0, c_addr}, 32'd49);
        chk("ab50.in_not_taken",   {16'd0, c_in},   32'd50);
        do_start("ab50.re");
        feed("ab50.re", 1, 1'b0, 1'b0, 16'h0);
        abort = 1'b1; step(); abort = 1'b0;

        // Reset after 70 transfers.
        do_start("rst70");
        feed("rst70", 70, 1'b0, 1'b0, 16'h0);
        s_valid = 1'b1; s_data = 16'h1234;
        #2 nrst = 1'b0;
        #1;
        chk_ctl("rst70.async", 0, 0, 0, 0);
        chk("rst70.c_addr", {24'd0, c_addr}, 32'd0);
        chk("rst70.c_in",   {16'd0, c_in},   32'd0);
        step();
        #2 nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ctl("rst70.quiet", 0, 0, 0, 0);
            chk("rst70.quiet_addr", {24'd0, c_addr}, 32'd0);
        end
        s_valid = 1'b0;
        do_start("rst70.re");
        feed("rst70.re", 1, 1'b0, 1'b0, 16'h0);
        abort = 1'b1; step(); abort = 1'b0;

`ifdef FIR_COEFF_CHECKSUM_EN
        // 129 * 0x0100 = 0x8100.
        exp_sum = 16'h8100;
        do_start("sum_ok");
        feed("sum_ok", NCOEF, 1'b0, 1'b1, 16'h0100);
        chk("sum_ok.flush", {31'd0, sum_ok}, 32'd0);
        finish_load("sum_ok");
        chk("sum_ok.match", {31'd0, sum_ok}, 32'd1);
        step();
        chk("sum_ok.hold", {31'd0, sum_ok}, 32'd1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("sum_ok.abort", {31'd0, sum_ok}, 32'd0);
        chk_ctl("sum_ok.abort", 0, 0, 0, 0);
        exp_sum = 16'h8101;
        do_start("sum_bad");
        feed("sum_bad", NCOEF, 1'b0, 1'b1, 16'h0100);
        finish_load("sum_bad");
        chk("sum_bad.mismatch", {31'd0, sum_ok}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
